// File: rtl/cmplx_mult_pkg.sv
// Shared types, field offsets and the sum reduction decision for the complex multiplier array.
// Define CMPLX_MULT_SAT_EN to saturate the sums instead of wrapping them.
package cmplx_mult_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} unit_state_e;
  typedef enum logic [1:0] {RED_KEEP, RED_POS, RED_NEG} reduce_e;

  // Field index of each component, in units of its own width, from the LSB end.
  localparam int A_RE_FIELD = 3;
  localparam int A_IM_FIELD = 2;
  localparam int B_RE_FIELD = 1;
  localparam int B_IM_FIELD = 0;
  localparam int P_RE_FIELD = 1;
  localparam int P_IM_FIELD = 0;

`ifdef CMPLX_MULT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // The two top bits of the widened sum disagree exactly when it overflows the narrow result.
  function automatic reduce_e reduce_mode(input logic sum_sign, input logic sum_msb);
    if (SAT_EN && !sum_sign && sum_msb) return RED_POS;
    if (SAT_EN && sum_sign && !sum_msb) return RED_NEG;
    return RED_KEEP;
  endfunction

endpackage

// File: rtl/complex_mult_unit.sv
// One two-stage complex multiply unit: operands latched on load, products, then reduced sums
// held in DONE until unloaded.
module complex_mult_unit
  import cmplx_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    unload,
  input  logic [4*DATA_WIDTH-1:0] op_data,
  output unit_state_e             state,
  output logic [4*DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  unit_state_e state_q, state_d;
  logic signed [W-1:0]  a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   sum_re, sum_im;

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = MUL;
      MUL:     state_d = ADD;
      ADD:     state_d = DONE;
      DONE:    if (unload) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_re <= '0;
      a_im <= '0;
      b_re <= '0;
      b_im <= '0;
    end else if (state_q == IDLE && load) begin
      a_re <= op_data[A_RE_FIELD*W +: W];
      a_im <= op_data[A_IM_FIELD*W +: W];
      b_re <= op_data[B_RE_FIELD*W +: W];
      b_im <= op_data[B_IM_FIELD*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (state_q == MUL) begin
      p_rr <= PW'(a_re) * PW'(b_re);
      p_ii <= PW'(a_im) * PW'(b_im);
      p_ri <= PW'(a_re) * PW'(b_im);
      p_ir <= PW'(a_im) * PW'(b_re);
    end
  end

  assign sum_re = (PW+1)'(p_rr) - (PW+1)'(p_ii);
  assign sum_im = (PW+1)'(p_ri) + (PW+1)'(p_ir);

  function automatic logic [PW-1:0] reduce(input logic signed [PW:0] s);
    unique case (reduce_mode(s[PW], s[PW-1]))
      RED_POS: return {1'b0, {(PW-1){1'b1}}};
      RED_NEG: return {1'b1, {(PW-1){1'b0}}};
      default: return s[PW-1:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (state_q == ADD) begin
      result[P_RE_FIELD*PW +: PW] <= reduce(sum_re);
      result[P_IM_FIELD*PW +: PW] <= reduce(sum_im);
    end
  end

endmodule

// File: rtl/complex_nr_mult_array.sv
// Round-robin array of complex multiply units with in-order result return.
// CMPLX_MULT_SAT_EN selects saturating instead of wrapping sum reduction.
module complex_nr_mult_array
  import cmplx_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_UNITS  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sw_rst,
  input  logic                           op_val,
  output logic                           op_ready,
  input  logic [4*DATA_WIDTH-1:0]        op_data,
  output logic                           res_val,
  input  logic                           res_ready,
  output logic [4*DATA_WIDTH-1:0]        res_data,
  output logic [$clog2(NUM_UNITS+1)-1:0] in_flight
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(NUM_UNITS + 1);

  logic                    reset;
  logic                    op_fire, res_fire;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  unit_state_e             unit_state  [NUM_UNITS];
  logic [4*DATA_WIDTH-1:0] unit_result [NUM_UNITS];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_UNITS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign reset    = rst | sw_rst;
  assign op_ready = (unit_state[wr_ptr] == IDLE) && !reset;
  assign res_val  = (unit_state[rd_ptr] == DONE);
  assign res_data = res_val ? unit_result[rd_ptr] : '0;
  assign op_fire  = op_val && op_ready;
  assign res_fire = res_val && res_ready;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    complex_mult_unit #(.DATA_WIDTH(DATA_WIDTH)) u_unit (
      .clk    (clk),
      .rst    (reset),
      .load   (op_fire && (wr_ptr == PTR_W'(i))),
      .unload (res_fire && (rd_ptr == PTR_W'(i))),
      .op_data(op_data),
      .state  (unit_state[i]),
      .result (unit_result[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (op_fire)  wr_ptr <= next_ptr(wr_ptr);
      if (res_fire) rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      unique case ({op_fire, res_fire})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
